proc_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the 8-bit 4-register processor datapath. It replaces free-running single-cycle commit with phased execution: FETCH, DECODE, EXEC, MEM, WB.
- Provides run, single-step and halt control, plus a PC breakpoint for board-level debugging.
- Sits between freq_divider (tick source) and the datapath. It gates the IR latch, PC update, register-file write and DMEM read/write enables.

---
 rtl/proc_ctrl_pkg.sv | 30 +++
 rtl/bp_unit.sv | 28 ++
 rtl/proc_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_proc_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the phased processor sequencer: FSM states, opcodes
// and halt-cause codes.
package proc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LD  = 2'b01;
   localparam logic [1:0] OP_ST  = 2'b10;
   localparam logic [1:0] OP_BR  = 2'b11;

   localparam logic [1:0] HC_NONE = 2'b00;
   localparam logic [1:0] HC_BP   = 2'b01;
   localparam logic [1:0] HC_REQ  = 2'b10;

   // True in the last phase of an instruction: the phase whose exit commits it.
   function automatic logic is_commit(input state_t s, input logic [1:0] op);
      return (s == S_WB) ||
             (s == S_EXEC && op == OP_BR) ||
             (s == S_MEM  && op == OP_ST);
   endfunction

endpackage

// File: rtl/bp_unit.sv
// PC breakpoint comparator with a one-shot skip flag that lets execution
// resume past the PC it stopped on.
module bp_unit #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            bp_en,
   input  logic [PC_W-1:0] bp_addr,
   input  logic [PC_W-1:0] pc,
   input  logic            skip_set,
   input  logic            skip_clr,
   output logic            hit,
   output logic            skip
);

   always_ff @(posedge clk) begin
      if (clr)
         skip <= 1'b0;
      else if (skip_set)
         skip <= 1'b1;
      else if (skip_clr)
         skip <= 1'b0;
   end

   assign hit = bp_en && (pc == bp_addr) && !skip;

endmodule

// File: rtl/proc_seq_ctrl.sv
// Multi-cycle sequencer: steps the datapath through FETCH/DECODE/EXEC/MEM/WB
// on each tick, with run, single-step, halt request and PC breakpoint control.
module proc_seq_ctrl
   import proc_ctrl_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             tick,
   input  logic             run,
   input  logic             step,
   input  logic             halt_req,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   input  logic [1:0]       op,
   output logic             ir_we,
   output logic             pc_we,
   output logic             reg_we,
   output logic             mem_re,
   output logic             mem_we,
   output logic [2:0]       state,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] instr_cnt
);

   state_t st;
   logic   cont;
   logic   step_pend;
   logic   halt_pend;
   logic   run_q;
   logic   bp_hit;
   logic   bp_skip;

   logic tk, fetch_ok, commit, run_fall, halt_now;
   logic launch_run, launch_step, skip_set;

   // clr suppresses every advance, so a reset mid-instruction emits no pulse
   assign tk          = tick && !clr;
   assign fetch_ok    = tk && (st == S_FETCH) && !bp_hit;
   assign commit      = tk && is_commit(st, op);
   assign run_fall    = run_q && !run;
   assign halt_now    = halt_pend || halt_req;
   assign launch_run  = tk && (st == S_IDLE) && run && !halted && !halt_req;
   assign launch_step = tk && (st == S_IDLE) && !launch_run && (step || step_pend);
   assign skip_set    = launch_step || (halted && run_fall);

   assign ir_we  = fetch_ok;
   assign pc_we  = commit;
   assign reg_we = tk && (st == S_WB);
   assign mem_we = tk && (st == S_MEM) && (op == OP_ST);
   assign mem_re = !clr && ((st == S_MEM) || (st == S_WB)) && (op == OP_LD);
   assign state  = st;

   bp_unit #(.PC_W(PC_W)) u_bp (
      .clk      (clk),
      .clr      (clr),
      .bp_en    (bp_en),
      .bp_addr  (bp_addr),
      .pc       (pc),
      .skip_set (skip_set),
      .skip_clr (fetch_ok),
      .hit      (bp_hit),
      .skip     (bp_skip)
   );

   // Later assignments deliberately override earlier ones within a cycle
   always_ff @(posedge clk) begin
      if (clr) begin
         st         <= S_IDLE;
         cont       <= 1'b0;
         step_pend  <= 1'b0;
         halt_pend  <= 1'b0;
         run_q      <= 1'b0;
         halted     <= 1'b0;
         halt_cause <= HC_NONE;
         instr_cnt  <= '0;
      end else begin
         run_q <= run;
         if (step && st == S_IDLE)
            step_pend <= 1'b1;
         if (halt_req && st != S_IDLE)
            halt_pend <= 1'b1;
         if (halted && run_fall) begin
            halted     <= 1'b0;
            halt_cause <= HC_NONE;
         end
         if (halt_req && st == S_IDLE) begin
            halted     <= 1'b1;
            halt_cause <= HC_REQ;
         end

         if (tk) begin
            case (st)
               S_IDLE: begin
                  if (launch_run) begin
                     st        <= S_FETCH;
                     cont      <= 1'b1;
                     step_pend <= 1'b0;
                  end else if (launch_step) begin
                     st        <= S_FETCH;
                     cont      <= 1'b0;
                     step_pend <= 1'b0;
                  end
               end
               S_FETCH: begin
                  if (bp_hit) begin
                     st         <= S_IDLE;
                     halted     <= 1'b1;
                     halt_cause <= HC_BP;
                     halt_pend  <= 1'b0;
                  end else begin
                     st <= S_DECODE;
                  end
               end
               S_DECODE: st <= S_EXEC;
               S_EXEC: begin
                  case (op)
                     OP_ADD:       st <= S_WB;
                     OP_LD, OP_ST: st <= S_MEM;
                     default:      ;
                  endcase
               end
               S_MEM: begin
                  if (op == OP_LD)
                     st <= S_WB;
               end
               default: ;
            endcase
         end

         if (commit) begin
            instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (halt_now) begin
               st         <= S_IDLE;
               halted     <= 1'b1;
               halt_cause <= HC_REQ;
               halt_pend  <= 1'b0;
            end else if (cont && run) begin
               st <= S_FETCH;
            end else begin
               st <= S_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Directed vector bench for proc_seq_ctrl; a second 4-bit-counter instance
// shares all inputs so the counter wrap is reached in a short run.
module tb_proc_seq_ctrl;

   logic       clk, clr, tick, run, step, halt_req, bp_en;
   logic [7:0] bp_addr, pc;
   logic [1:0] op;
   logic       ir_we, pc_we, reg_we, mem_re, mem_we, halted;
   logic [2:0] state;
   logic [1:0] halt_cause;
   logic [15:0] instr_cnt;
   logic       s_ir_we, s_pc_we, s_reg_we, s_mem_re, s_mem_we, s_halted;
   logic [2:0] s_state;
   logic [1:0] s_halt_cause;
   logic [3:0] s_instr_cnt;

   proc_seq_ctrl dut (
      .clk(clk), .clr(clr), .tick(tick), .run(run), .step(step),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .op(op),
      .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .mem_re(mem_re),
      .mem_we(mem_we), .state(state), .halted(halted),
      .halt_cause(halt_cause), .instr_cnt(instr_cnt)
   );

   proc_seq_ctrl #(.PC_W(8), .CNT_W(4)) u_small (
      .clk(clk), .clr(clr), .tick(tick), .run(run), .step(step),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .op(op),
      .ir_we(s_ir_we), .pc_we(s_pc_we), .reg_we(s_reg_we), .mem_re(s_mem_re),
      .mem_we(s_mem_we), .state(s_state), .halted(s_halted),
      .halt_cause(s_halt_cause), .instr_cnt(s_instr_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       clr, tick, run, step, hreq, bpen;
      logic [7:0] pc;
      logic [1:0] op;
      logic [4:0] ep;   // {ir_we, pc_we, reg_we, mem_re, mem_we} before the edge
      logic [2:0] es;   // state after the edge
      logic       eh;
      logic [1:0] ec;
   } vec_t;

   vec_t       q[$];
   int         checks = 0;
   int         failures = 0;
   logic [15:0] exp_cnt = '0;
   logic       r, b;
   logic [1:0] o;
   logic [7:0] p;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, expv);
      end
   endtask

   task automatic add(input logic c, input logic t, input logic s, input logic h,
                      input logic [4:0] ep, input logic [2:0] es,
                      input logic eh, input logic [1:0] ec);
      vec_t x;
      x.clr = c;  x.tick = t;  x.step = s;  x.hreq = h;
      x.run = r;  x.op = o;    x.pc = p;    x.bpen = b;
      x.ep = ep;  x.es = es;   x.eh = eh;   x.ec = ec;
      q.push_back(x);
   endtask

   task automatic apply(input vec_t x, input int idx);
      @(negedge clk);
      clr = x.clr;  tick = x.tick;  run = x.run;  step = x.step;
      halt_req = x.hreq;  bp_en = x.bpen;  pc = x.pc;  op = x.op;
      #1;
      chk("pulses", idx, {27'd0, ir_we, pc_we, reg_we, mem_re, mem_we}, {27'd0, x.ep});
      if (x.clr)
         exp_cnt = '0;
      else if (x.ep[3])
         exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
      chk("state", idx, {29'd0, state}, {29'd0, x.es});
      chk("halted", idx, {31'd0, halted}, {31'd0, x.eh});
      chk("cause", idx, {30'd0, halt_cause}, {30'd0, x.ec});
      chk("instr_cnt", idx, {16'd0, instr_cnt}, {16'd0, exp_cnt});
      chk("cnt_wrap4", idx, {28'd0, s_instr_cnt}, {28'd0, exp_cnt[3:0]});
   endtask

   initial begin
      clr = 1'b0; tick = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
      bp_en = 1'b0; bp_addr = 8'h05; pc = 8'h00; op = 2'b00;

      // reset with run high and tick pulsing
      r = 1; o = 2'b00; p = 8'h00; b = 0;
      add(1,1,0,0, 5'b00000, 3'd0, 0, 2'b00);
      add(1,1,0,0, 5'b00000, 3'd0, 0, 2'b00);
      // continuous ADD
      add(0,0,0,0, 5'b00000, 3'd0, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd1, 0, 2'b00);
      add(0,0,0,0, 5'b00000, 3'd1, 0, 2'b00);
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd5, 0, 2'b00);
      add(0,0,0,0, 5'b00000, 3'd5, 0, 2'b00);
      add(0,1,0,0, 5'b01100, 3'd1, 0, 2'b00);
      // drop run: current ADD finishes, then IDLE
      r = 0;
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd5, 0, 2'b00);
      add(0,1,0,0, 5'b01100, 3'd0, 0, 2'b00);
      // single-step LD, step latched off-tick
      o = 2'b01;
      add(0,0,1,0, 5'b00000, 3'd0, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd1, 0, 2'b00);
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd4, 0, 2'b00);
      add(0,0,0,0, 5'b00010, 3'd4, 0, 2'b00);
      add(0,1,0,0, 5'b00010, 3'd5, 0, 2'b00);
      add(0,1,0,0, 5'b01110, 3'd0, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd0, 0, 2'b00);
      // breakpoint at 0x05
      r = 1; o = 2'b00; p = 8'h04; b = 1;
      add(0,1,0,0, 5'b00000, 3'd1, 0, 2'b00);
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd5, 0, 2'b00);
      add(0,1,0,0, 5'b01100, 3'd1, 0, 2'b00);
      p = 8'h05;
      add(0,1,0,0, 5'b00000, 3'd0, 1, 2'b01);
      add(0,1,0,0, 5'b00000, 3'd0, 1, 2'b01);
      add(0,0,1,0, 5'b00000, 3'd0, 1, 2'b01);
      add(0,1,0,0, 5'b00000, 3'd1, 1, 2'b01);
      add(0,1,0,0, 5'b10000, 3'd2, 1, 2'b01);
      add(0,1,0,0, 5'b00000, 3'd3, 1, 2'b01);
      add(0,1,0,0, 5'b00000, 3'd5, 1, 2'b01);
      add(0,1,0,0, 5'b01100, 3'd0, 1, 2'b01);
      r = 0; p = 8'h06;
      add(0,0,0,0, 5'b00000, 3'd0, 0, 2'b00);
      // halt request during EXEC of BR
      r = 1; o = 2'b11; b = 0;
      add(0,1,0,0, 5'b00000, 3'd1, 0, 2'b00);
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,0,0,1, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b01000, 3'd0, 1, 2'b10);
      add(0,1,0,0, 5'b00000, 3'd0, 1, 2'b10);
      add(0,1,0,0, 5'b00000, 3'd0, 1, 2'b10);
      r = 0;
      add(0,0,0,0, 5'b00000, 3'd0, 0, 2'b00);
      r = 1;
      add(0,1,0,0, 5'b00000, 3'd1, 0, 2'b00);
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b01000, 3'd1, 0, 2'b00);
      // ten back-to-back BRs carry the 4-bit counter through its wrap
      for (int k = 0; k < 10; k++) begin
         add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
         add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
         add(0,1,0,0, 5'b01000, 3'd1, 0, 2'b00);
      end
      // pending halt and breakpoint at the same FETCH: breakpoint wins, request dropped
      add(0,0,0,1, 5'b00000, 3'd1, 0, 2'b00);
      p = 8'h05; b = 1;
      add(0,1,0,0, 5'b00000, 3'd0, 1, 2'b01);
      r = 0;
      add(0,0,0,0, 5'b00000, 3'd0, 0, 2'b00);
      r = 1; p = 8'h06; b = 0;
      add(0,1,0,0, 5'b00000, 3'd1, 0, 2'b00);
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b01000, 3'd1, 0, 2'b00);
      // clr on the tick that would leave MEM of ST
      o = 2'b10;
      add(0,1,0,0, 5'b10000, 3'd2, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd3, 0, 2'b00);
      add(0,1,0,0, 5'b00000, 3'd4, 0, 2'b00);
      add(0,0,0,0, 5'b00000, 3'd4, 0, 2'b00);
      add(1,1,0,0, 5'b00000, 3'd0, 0, 2'b00);
      r = 0;
      add(0,1,0,0, 5'b00000, 3'd0, 0, 2'b00);
      // halt request while idle takes effect immediately
      add(0,0,0,1, 5'b00000, 3'd0, 1, 2'b10);
      add(0,1,0,0, 5'b00000, 3'd0, 1, 2'b10);

      foreach (q[i]) apply(q[i], i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
